bin2bcd: RTL and testbench

Sequential binary-to-BCD converter placed directly downstream of the 16-bit divider core. It consumes the quotient in result[15:0] and starts on the divider's done. It converts the quotient with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It produces 5 packed BCD digits for the display/UART peripheral path.

---
 rtl/bin2bcd_pkg.sv | 19 +
 rtl/bin2bcd_digit_adj.sv | 9 +
 rtl/bin2bcd.sv | 89 ++++++++
 tb/tb_bin2bcd.sv | 138 +++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared constants, state encoding and sizing helper for the BCD converter
package bin2bcd_pkg;
   localparam int WIDTH_DEF = 16;
   localparam int DIGITS_DEF = 5;
   localparam logic [3:0] ADJ_THRESH = 4'd5;
   typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, FINISH = 2'd2, WAIT_LOW = 2'd3} state_e;
   function automatic int dec_digits(input int width);
      longint m;
      int n;
      m = (longint'(1) << width) - 1;
      n = 1;
      for (int i = 0; i < 20; i++)
         if (m >= 10) begin
            m = m / 10;
            n = n + 1;
         end
      return n;
   endfunction
endpackage

// File: rtl/bin2bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble cell, adds 3 to a BCD digit of 5 or more
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= ADJ_THRESH) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd.sv
// bin2bcd: sequential double-dabble binary-to-BCD converter, one bit per clock
module bin2bcd
   import bin2bcd_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init,
   input  logic [WIDTH-1:0]      in_bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;
   if (DIGITS < dec_digits(WIDTH)) begin : g_size_chk
      $error("bin2bcd: DIGITS too small to hold 2**WIDTH-1");
   end
   state_e state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0] scratch_q, scratch_d, bcd_q, bcd_d, adj;
   logic busy_q, busy_d, done_q, done_d;
   logic [BW+WIDTH-1:0] sh;
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (.d(scratch_q[4*i +: 4]), .q(adj[4*i +: 4]));
   end
   assign sh = {adj, shift_q} << 1;
   // next-state logic: latch operand, iterate adjust+shift, publish result, wait for init low
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      shift_d = shift_q;
      scratch_d = scratch_q;
      bcd_d = bcd_q;
      busy_d = busy_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: if (init) begin
            shift_d = in_bin;
            scratch_d = '0;
            count_d = CW'(WIDTH);
            busy_d = 1'b1;
            state_d = CONV;
         end
         CONV: begin
            {scratch_d, shift_d} = sh;
            count_d = count_q - 1'b1;
            state_d = (count_q == CW'(1)) ? FINISH : CONV;
         end
         FINISH: begin
            bcd_d = scratch_q;
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = init ? WAIT_LOW : IDLE;
         end
         WAIT_LOW: state_d = init ? WAIT_LOW : IDLE;
         default: begin
            state_d = IDLE;
            busy_d = 1'b0;
         end
      endcase
   end
   // state registers; reset aborts any conversion in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         shift_q <= '0;
         scratch_q <= '0;
         bcd_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         shift_q <= shift_d;
         scratch_q <= scratch_d;
         bcd_q <= bcd_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign bcd = bcd_q;
endmodule

// File: tb/tb_bin2bcd.sv
// tb_bin2bcd: directed and random conversions checked against a decimal reference model
module tb_bin2bcd;
   logic clk = 1'b0;
   logic reset, init;
   logic [15:0] in_bin;
   logic busy, done;
   logic [19:0] bcd;
   int checks = 0;
   int errors = 0;

   bin2bcd dut (.clk(clk), .reset(reset), .init(init), .in_bin(in_bin), .busy(busy), .done(done), .bcd(bcd));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // decimal digits from plain division, digit 0 in the low nibble
   function automatic logic [19:0] ref_bcd(input int n);
      logic [19:0] r;
      r = '0;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      init = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("idle_done", done, 0);
         chk("idle_busy", busy, 0);
      end
   endtask

   // starts at a negedge; init held for hold cycles, optional extra init pulse at pulse_at
   task automatic convert(input int v, input int hold, input int pulse_at);
      logic [19:0] exp;
      exp = ref_bcd(v);
      in_bin = 16'(v);
      init = 1'b1;
      for (int e = 1; e <= 60; e++) begin
         @(negedge clk);
         if (e == hold) init = 1'b0;
         if (e == 3) in_bin = 16'($urandom);
         if (pulse_at > 0 && e == pulse_at) begin
            init = 1'b1;
            in_bin = 16'd999;
         end
         if (pulse_at > 0 && e == pulse_at + 1) init = 1'b0;
         if (e == 1 || e == 17) chk("busy_during", busy, 1);
         if (e < 18) chk("done_early", done, 0);
         if (e == 18) begin
            chk("done_pulse", done, 1);
            chk("busy_after", busy, 0);
            chk("bcd_value", bcd, exp);
         end
         if (e > 18) begin
            chk("done_retrigger", done, 0);
            chk("busy_retrigger", busy, 0);
            chk("bcd_hold", bcd, exp);
         end
         if (e >= 18 && e >= hold) break;
      end
   endtask

   initial begin
      reset = 1'b1;
      init = 1'b0;
      in_bin = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bcd", bcd, 0);
      reset = 1'b0;
      @(negedge clk);
      convert(0, 1, 0);
      idle(2);
      convert(65535, 1, 0);
      idle(1);
      convert(1234, 1, 0);
      idle(1);
      convert(9, 1, 0);
      idle(1);
      convert(407, 5, 0);
      idle(3);
      convert(8191, 25, 0);
      idle(3);
      convert(500, 1, 4);
      idle(20);
      in_bin = 16'd777;
      init = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         init = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_bcd", bcd, 0);
      idle(20);
      convert(31415, 1, 0);
      reset = 1'b1;
      init = 1'b1;
      in_bin = 16'd1111;
      @(negedge clk);
      chk("rst_init_busy", busy, 0);
      chk("rst_init_bcd", bcd, 0);
      reset = 1'b0;
      idle(20);
      convert(42, 1, 0);
      convert(10000, 1, 0);
      convert(59999, 2, 0);
      idle(1);
      for (int n = 0; n < 16; n++) begin
         convert(int'($urandom_range(0, 65535)), int'($urandom_range(1, 4)), 0);
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
